// File: rtl/game_pkg.sv
// Shared definitions for the lamp ping-pong game: match states, field
// widths and side encoding used by both the match sequencer and the rally engine.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_SERVE_WAIT  = 3'd1,
    ST_RALLY       = 3'd2,
    ST_POINT_PAUSE = 3'd3,
    ST_MATCH_END   = 3'd4
  } state_t;

  localparam int SCORE_W       = 4;
  localparam int SPEED_W       = 3;
  localparam int WIN_SCORE_DEF = 9;

  // Side encoding: also the serve direction (left serves -> ball travels left to right).
  localparam logic SIDE_LEFT  = 1'b1;
  localparam logic SIDE_RIGHT = 1'b0;

endpackage

// File: rtl/match_sequencer_if.sv
// Signals between the match sequencer and the rally engine / front panel.
// The sequencer uses the slave view; the environment drives through master.
interface match_sequencer_if
  import game_pkg::*;
();

  logic               start_btn;
  logic               serve_ack;
  logic               hit;
  logic               point_left;
  logic               point_right;
  logic               step_en;
  logic               serve_req;
  logic               serve_side;
  logic               game_run;
  logic [SPEED_W-1:0] speed_level;
  logic [SCORE_W-1:0] score_left;
  logic [SCORE_W-1:0] score_right;
  logic               match_over;
  logic               winner;

  modport master (
    output start_btn, serve_ack, hit, point_left, point_right,
    input  step_en, serve_req, serve_side, game_run, speed_level,
           score_left, score_right, match_over, winner
  );

  modport slave (
    input  start_btn, serve_ack, hit, point_left, point_right,
    output step_en, serve_req, serve_side, game_run, speed_level,
           score_left, score_right, match_over, winner
  );

endinterface

// File: rtl/match_sequencer_step_timer.sv
// Free-running period timer for the ball-step strobe. The period may change
// while counting; a count already at or past the new last value fires at once.
module step_timer #(
  parameter int CNT_W = 27
) (
  input  logic             clk_game,
  input  logic             rst,
  input  logic [CNT_W-1:0] period,
  input  logic             enable,
  input  logic             clear,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;

  assign tick = enable && (cnt >= (period - CNT_W'(1)));

  // Count enabled cycles, wrapping to zero on each tick.
  always_ff @(posedge clk_game) begin
    // NOTE: sequential state always uses non-blocking assignment so every
    // register samples pre-edge values, independent of block ordering.
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/match_sequencer.sv
// Match-level controller: sequences serve, rally, point pause and match end,
// keeps scores and speed level, and produces the ball-step strobe.
module match_sequencer
  import game_pkg::*;
#(
  parameter int STEP_BASE = 12_500_000,
  parameter int STEP_DEC  = 1_000_000,
  parameter int MIN_STEP  = 2_500_000,
  parameter int PAUSE_CYC = 50_000_000,
  parameter int WIN_SCORE = WIN_SCORE_DEF,
  parameter int CNT_W     = 27
) (
  input  logic             clk_game,
  input  logic             rst,
  match_sequencer_if.slave bus
);

  localparam int                 PER_W      = CNT_W + 3;
  localparam logic [PER_W-1:0]   PER_BASE   = PER_W'(STEP_BASE);
  localparam logic [PER_W-1:0]   PER_MIN    = PER_W'(MIN_STEP);
  localparam logic [CNT_W-1:0]   PAUSE_LAST = CNT_W'(PAUSE_CYC - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);
  localparam logic [SPEED_W-1:0] SPEED_MAX  = '1;

  state_t             state, state_nx;
  logic [SCORE_W-1:0] score_l, score_l_nx;
  logic [SCORE_W-1:0] score_r, score_r_nx;
  logic [SPEED_W-1:0] speed, speed_nx;
  logic               side, side_nx;
  logic               winner_q, winner_nx;
  logic [CNT_W-1:0]   pause_cnt, pause_cnt_nx;
  logic               timer_clear;
  logic               run_en;
  logic               step_tick;
  logic [PER_W-1:0]   dec_amt;
  logic [PER_W-1:0]   per_raw;
  logic [PER_W-1:0]   per_sel;
  logic [CNT_W-1:0]   step_period;

  // Step period for the current speed level, floored at MIN_STEP without underflow.
  always_comb begin
    dec_amt = PER_W'(speed) * PER_W'(STEP_DEC);
    per_raw = '0;
    per_sel = PER_MIN;
    if (dec_amt < PER_BASE) begin
      per_raw = PER_BASE - dec_amt;
      per_sel = (per_raw < PER_MIN) ? PER_MIN : per_raw;
    end
  end

  assign step_period = CNT_W'(per_sel);
  assign run_en      = (state == ST_RALLY);

  step_timer #(
    .CNT_W (CNT_W)
  ) u_step_timer (
    .clk_game (clk_game),
    .rst      (rst),
    .period   (step_period),
    .enable   (run_en),
    .clear    (timer_clear),
    .tick     (step_tick)
  );

  // Next-state and next-datapath decisions for the match FSM.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_nx     = state;
    score_l_nx   = score_l;
    score_r_nx   = score_r;
    speed_nx     = speed;
    side_nx      = side;
    winner_nx    = winner_q;
    pause_cnt_nx = pause_cnt;
    timer_clear  = 1'b0;

    case (state)
      ST_IDLE, ST_MATCH_END: begin
        if (bus.start_btn) begin
          state_nx   = ST_SERVE_WAIT;
          score_l_nx = '0;
          score_r_nx = '0;
          side_nx    = SIDE_LEFT;
        end
      end

      ST_SERVE_WAIT: begin
        if (bus.serve_ack) begin
          state_nx    = ST_RALLY;
          speed_nx    = '0;
          timer_clear = 1'b1;
        end
      end

      ST_RALLY: begin
        if (bus.point_left || bus.point_right) begin
          // A point always beats a simultaneous hit; both points at once is a let.
          state_nx     = ST_POINT_PAUSE;
          pause_cnt_nx = '0;
          if (bus.point_left && !bus.point_right) begin
            score_l_nx = (score_l == SCORE_MAX) ? score_l : score_l + SCORE_W'(1);
            side_nx    = SIDE_RIGHT;
          end else if (bus.point_right && !bus.point_left) begin
            score_r_nx = (score_r == SCORE_MAX) ? score_r : score_r + SCORE_W'(1);
            side_nx    = SIDE_LEFT;
          end
        end else if (bus.hit && (speed != SPEED_MAX)) begin
          speed_nx = speed + SPEED_W'(1);
        end
      end

      ST_POINT_PAUSE: begin
        if (pause_cnt == PAUSE_LAST) begin
          if ((score_l == WIN) || (score_r == WIN)) begin
            state_nx  = ST_MATCH_END;
            winner_nx = (score_l == WIN);
          end else begin
            state_nx = ST_SERVE_WAIT;
          end
        end else begin
          pause_cnt_nx = pause_cnt + CNT_W'(1);
        end
      end

      default: state_nx = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_game) begin
    if (rst) begin
      state     <= ST_IDLE;
      score_l   <= '0;
      score_r   <= '0;
      speed     <= '0;
      side      <= SIDE_LEFT;
      winner_q  <= 1'b0;
      pause_cnt <= '0;
    end else begin
      state     <= state_nx;
      score_l   <= score_l_nx;
      score_r   <= score_r_nx;
      speed     <= speed_nx;
      side      <= side_nx;
      winner_q  <= winner_nx;
      pause_cnt <= pause_cnt_nx;
    end
  end

  assign bus.step_en     = step_tick;
  assign bus.serve_req   = (state == ST_SERVE_WAIT);
  assign bus.game_run    = run_en;
  assign bus.match_over  = (state == ST_MATCH_END);
  assign bus.serve_side  = side;
  assign bus.speed_level = speed;
  assign bus.score_left  = score_l;
  assign bus.score_right = score_r;
  assign bus.winner      = winner_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Bench for match_sequencer: directed scenarios with literal expectations
// plus randomized play, all checked every cycle against a time-based model.
module tb_match_sequencer;

  localparam int STEP_BASE = 10;
  localparam int STEP_DEC  = 2;
  localparam int MIN_STEP  = 4;
  localparam int PAUSE_CYC = 5;
  localparam int WIN_SCORE = 3;
  localparam int CNT_W     = 27;

  logic clk_game = 1'b0;
  logic rst      = 1'b1;

  match_sequencer_if bus ();

  match_sequencer #(
    .STEP_BASE (STEP_BASE),
    .STEP_DEC  (STEP_DEC),
    .MIN_STEP  (MIN_STEP),
    .PAUSE_CYC (PAUSE_CYC),
    .WIN_SCORE (WIN_SCORE),
    .CNT_W     (CNT_W)
  ) dut (
    .clk_game (clk_game),
    .rst      (rst),
    .bus      (bus)
  );

  always #5 clk_game = ~clk_game;

  int cyc = 0;
  always @(posedge clk_game) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model (absolute-time view) ----------------
  typedef enum int {P_IDLE, P_SERVE, P_PLAY, P_PAUSE, P_OVER} phase_t;

  phase_t m_ph = P_IDLE;
  int     m_sl, m_sr, m_side, m_spd, m_win, m_last, m_pause_end;
  bit     m_valid = 1'b0;
  bit     exp_step;

  function automatic int period_of(input int spd);
    int p;
    p = STEP_BASE - spd * STEP_DEC;
    return (p < MIN_STEP) ? MIN_STEP : p;
  endfunction

  initial begin
    forever begin
      @(negedge clk_game);
      exp_step = (m_ph == P_PLAY) && ((cyc - m_last) >= period_of(m_spd));
      if (m_valid) begin
        check("step_en",     bus.step_en,     32'(exp_step));
        check("serve_req",   bus.serve_req,   32'(m_ph == P_SERVE));
        check("game_run",    bus.game_run,    32'(m_ph == P_PLAY));
        check("match_over",  bus.match_over,  32'(m_ph == P_OVER));
        check("serve_side",  bus.serve_side,  32'(m_side));
        check("speed_level", bus.speed_level, 32'(m_spd));
        check("score_left",  bus.score_left,  32'(m_sl));
        check("score_right", bus.score_right, 32'(m_sr));
        check("winner",      bus.winner,      32'(m_win));
      end
      if (rst === 1'b1) begin
        m_ph = P_IDLE; m_sl = 0; m_sr = 0; m_side = 1; m_spd = 0; m_win = 0;
        m_valid = 1'b1;
      end else if (m_valid) begin
        case (m_ph)
          P_IDLE, P_OVER: if (bus.start_btn) begin
            m_ph = P_SERVE; m_sl = 0; m_sr = 0; m_side = 1;
          end
          P_SERVE: if (bus.serve_ack) begin
            m_ph = P_PLAY; m_spd = 0; m_last = cyc;
          end
          P_PLAY: begin
            if (exp_step) m_last = cyc;
            if (bus.point_left || bus.point_right) begin
              if (bus.point_left && !bus.point_right) begin
                m_sl = (m_sl < 15) ? m_sl + 1 : 15; m_side = 0;
              end else if (bus.point_right && !bus.point_left) begin
                m_sr = (m_sr < 15) ? m_sr + 1 : 15; m_side = 1;
              end
              m_ph = P_PAUSE;
              m_pause_end = cyc + 1 + PAUSE_CYC;
            end else if (bus.hit && m_spd < 7) begin
              m_spd = m_spd + 1;
            end
          end
          P_PAUSE: if (cyc + 1 == m_pause_end) begin
            if (m_sl == WIN_SCORE || m_sr == WIN_SCORE) begin
              m_ph = P_OVER; m_win = (m_sl == WIN_SCORE) ? 1 : 0;
            end else begin
              m_ph = P_SERVE;
            end
          end
          default: m_ph = P_IDLE;
        endcase
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step_cyc();
    @(posedge clk_game);
    #1;
  endtask

  task automatic apply(input logic s, input logic a, input logic h, input logic pl, input logic pr);
    bus.start_btn = s; bus.serve_ack = a; bus.hit = h; bus.point_left = pl; bus.point_right = pr;
    step_cyc();
    bus.start_btn = 0; bus.serve_ack = 0; bus.hit = 0; bus.point_left = 0; bus.point_right = 0;
  endtask

  task automatic wait_step(output int at, input int limit);
    bit seen;
    seen = 0;
    at = -1;
    for (int i = 0; i < limit && !seen; i++) begin
      if (bus.step_en === 1'b1) begin
        at = cyc;
        seen = 1;
      end
      step_cyc();
    end
    if (!seen) begin
      n_cmp++; n_err++;
      $display("FAIL step_timeout at cycle %0d: no step_en within %0d cycles", cyc, limit);
    end
  endtask

  // sel 0: serve_req, sel 1: match_over
  task automatic wait_sig(input int sel, output int n, input int limit);
    logic v;
    n = 0;
    v = (sel == 0) ? bus.serve_req : bus.match_over;
    while (v !== 1'b1 && n < limit) begin
      step_cyc();
      n++;
      v = (sel == 0) ? bus.serve_req : bus.match_over;
    end
    if (v !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL wait_timeout at cycle %0d: signal %0d not seen within %0d cycles", cyc, sel, limit);
    end
  endtask

  task automatic rally_point_left(input int sel);
    int n;
    apply(0, 1, 0, 0, 0);
    step_cyc();
    step_cyc();
    apply(0, 0, 0, 1, 0);
    wait_sig(sel, n, 20);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_step_en"},    bus.step_en,     0);
    check({tag, "_serve_req"},  bus.serve_req,   0);
    check({tag, "_serve_side"}, bus.serve_side,  1);
    check({tag, "_game_run"},   bus.game_run,    0);
    check({tag, "_speed"},      bus.speed_level, 0);
    check({tag, "_score_l"},    bus.score_left,  0);
    check({tag, "_score_r"},    bus.score_right, 0);
    check({tag, "_match_over"}, bus.match_over,  0);
    check({tag, "_winner"},     bus.winner,      0);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int t0, s0, s1, n;
    bus.start_btn = 0; bus.serve_ack = 0; bus.hit = 0; bus.point_left = 0; bus.point_right = 0;
    rst = 1'b1;
    repeat (3) step_cyc();
    rst = 1'b0;
    check_reset_outputs("rst");

    // 1: serve and base step period
    apply(1, 0, 0, 0, 0);
    step_cyc();
    check("serve_req_before_ack", bus.serve_req, 1);
    t0 = cyc;
    apply(0, 1, 0, 0, 0);
    check("serve_req_after_ack", bus.serve_req, 0);
    check("game_run_after_ack", bus.game_run, 1);
    wait_step(s0, 30);
    check("first_step_latency", 32'(s0 - t0), 10);
    for (int k = 0; k < 2; k++) begin
      wait_step(s1, 30);
      check("base_step_spacing", 32'(s1 - s0), 10);
      s0 = s1;
    end

    // 2: speed-up after each step, down to the floor
    for (int k = 0; k < 4; k++) begin
      apply(0, 0, 1, 0, 0);
      wait_step(s1, 30);
      case (k)
        0: check("spacing_speed1", 32'(s1 - s0), 8);
        1: check("spacing_speed2", 32'(s1 - s0), 6);
        2: check("spacing_speed3", 32'(s1 - s0), 4);
        default: check("spacing_speed4", 32'(s1 - s0), 4);
      endcase
      s0 = s1;
    end
    check("speed_after_4_hits", bus.speed_level, 4);
    wait_step(s1, 30);
    check("spacing_floor", 32'(s1 - s0), 4);

    // 3: single left point
    apply(0, 0, 0, 1, 0);
    check("pt_score_left", bus.score_left, 1);
    check("pt_serve_side", bus.serve_side, 0);
    check("pt_step_en", bus.step_en, 0);
    check("pt_serve_req", bus.serve_req, 0);
    wait_sig(0, n, 20);
    check("pause_length", 32'(n), 5);

    // 4: left wins the match
    rally_point_left(0);
    rally_point_left(1);
    check("end_match_over", bus.match_over, 1);
    check("end_winner", bus.winner, 1);
    check("end_score_left", bus.score_left, 3);
    apply(1, 0, 0, 0, 0);
    check("restart_match_over", bus.match_over, 0);
    check("restart_score_left", bus.score_left, 0);
    check("restart_serve_side", bus.serve_side, 1);

    // 5: simultaneous events
    apply(0, 1, 0, 0, 0);
    step_cyc();
    apply(0, 0, 0, 1, 1);
    check("let_score_left", bus.score_left, 0);
    check("let_score_right", bus.score_right, 0);
    check("let_serve_side", bus.serve_side, 1);
    check("let_in_pause", bus.game_run, 0);
    wait_sig(0, n, 20);
    apply(0, 1, 0, 0, 0);
    apply(0, 0, 1, 0, 0);
    check("hit_speed", bus.speed_level, 1);
    apply(0, 0, 1, 0, 1);
    check("hit_pt_speed", bus.speed_level, 1);
    check("hit_pt_score_right", bus.score_right, 1);
    wait_sig(0, n, 20);

    // 6: reset mid-rally
    rally_point_left(0);
    rally_point_left(0);
    apply(0, 1, 0, 0, 0);
    repeat (3) apply(0, 0, 1, 0, 0);
    check("pre_rst_speed", bus.speed_level, 3);
    check("pre_rst_score_left", bus.score_left, 2);
    check("pre_rst_score_right", bus.score_right, 1);
    rst = 1'b1;
    step_cyc();
    check_reset_outputs("mid_rst");
    step_cyc();
    rst = 1'b0;
    apply(0, 1, 0, 0, 0);
    check("ack_ignored_run", bus.game_run, 0);
    check("ack_ignored_serve", bus.serve_req, 0);

    // Randomized play
    for (int i = 0; i < 4000; i++) begin
      rst             = ($urandom_range(0, 499) == 0);
      bus.start_btn   = ($urandom_range(0, 7) == 0);
      bus.serve_ack   = ($urandom_range(0, 3) == 0);
      bus.hit         = ($urandom_range(0, 5) == 0);
      bus.point_left  = ($urandom_range(0, 24) == 0);
      bus.point_right = ($urandom_range(0, 24) == 0);
      step_cyc();
    end
    rst = 1'b0;
    bus.start_btn = 0; bus.serve_ack = 0; bus.hit = 0; bus.point_left = 0; bus.point_right = 0;
    repeat (3) step_cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
